// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage between the PC logic and decode.
// Issues in-order reads at the current PC and tags each read with its PC in a
// small circular reservation buffer. It presents {pc, inst} to decode over a
// valid/ready handshake. A redirect flushes the buffer, and any read still in
// flight is counted so that its response is discarded when it arrives.
// Optional build macro: FETCH_QUEUE_BYPASS_EN. When it is defined, a response
// that fills the unfilled head entry is forwarded to decode in the same cycle.
module fetch_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'hE1A00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        redirect,
    output logic        pc_update,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    input  logic        id_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Per-entry control flags (reset) and payload (not reset)
    logic [DEPTH-1:0] alloc_q, alloc_d;
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] aptr_q, aptr_d;
    logic [PW-1:0] fptr_q, fptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] drop_q, drop_d;

    logic          req_fire;
    logic          resp_keep;
    logic          resp_drop;
    logic          head_ready;
    logic          bypass;
    logic          id_fire;
    logic [CW-1:0] unfilled;

    // Request side: issue while there is room and no flush is in progress
    always_comb begin
        imem_req_valid = !reset && !redirect && (count_q < CW'(DEPTH));
        req_fire       = imem_req_valid && imem_req_ready;
        pc_update      = req_fire || (!reset && redirect);
        imem_req_addr  = pc;
    end

    // Response classification: stale responses from before a flush are dropped
    always_comb begin
        resp_keep = imem_resp_valid && (drop_q == '0);
        resp_drop = imem_resp_valid && (drop_q != '0);
    end

    // Decode side: head entry presentation, with the optional same-cycle forward
    always_comb begin
        // NOTE: every signal written here is given a default first, so that no path infers a latch.
        id_inst    = NOP_INST;
        id_pc      = '0;
        head_ready = alloc_q[head_q] && filled_q[head_q];
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass     = resp_keep && alloc_q[head_q] && !filled_q[head_q] && (fptr_q == head_q);
`else
        bypass     = 1'b0;
`endif
        id_valid   = !reset && !redirect && (head_ready || bypass);
        id_fire    = id_valid && id_ready;
        if (id_valid) begin
            id_pc   = pc_q[head_q];
            id_inst = head_ready ? inst_q[head_q] : imem_resp_data;
        end
    end

    // Count allocated-but-unfilled entries; these become stale reads on a flush
    always_comb begin
        unfilled = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            unfilled = unfilled + CW'(alloc_q[i] & ~filled_q[i]);
        end
    end

    // Next-state for flags, pointers, occupancy and the drop counter
    always_comb begin
        alloc_d  = alloc_q;
        filled_d = filled_q;
        head_d   = head_q;
        aptr_d   = aptr_q;
        fptr_d   = fptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (redirect) begin
            alloc_d  = '0;
            filled_d = '0;
            head_d   = '0;
            aptr_d   = '0;
            fptr_d   = '0;
            count_d  = '0;
            // A response arriving now retires one outstanding read, whether it
            // was already stale or belonged to an entry that is being flushed.
            drop_d   = drop_q + unfilled - CW'(imem_resp_valid);
        end else begin
            if (resp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            if (resp_keep) begin
                filled_d[fptr_q] = 1'b1;
                fptr_d           = fptr_q + PW'(1);
            end
            // The head is freed after the fill, so a forwarded response leaves no trace.
            if (id_fire) begin
                alloc_d[head_q]  = 1'b0;
                filled_d[head_q] = 1'b0;
                head_d           = head_q + PW'(1);
            end
            if (req_fire) begin
                alloc_d[aptr_q]  = 1'b1;
                filled_d[aptr_q] = 1'b0;
                aptr_d           = aptr_q + PW'(1);
            end
            count_d = count_q + CW'(req_fire) - CW'(id_fire);
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (reset) begin
            alloc_q  <= '0;
            filled_q <= '0;
            head_q   <= '0;
            aptr_q   <= '0;
            fptr_q   <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            alloc_q  <= alloc_d;
            filled_q <= filled_d;
            head_q   <= head_d;
            aptr_q   <= aptr_d;
            fptr_q   <= fptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Payload capture: PC tag on allocation, instruction word on fill
    always_ff @(posedge clk) begin
        // NOTE: the payload arrays are not reset. The alloc and filled flags gate every read, so stale contents are never observed.
        if (req_fire) begin
            pc_q[aptr_q] <= pc;
        end
        if (resp_keep && !redirect) begin
            inst_q[fptr_q] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue.
// A queue-based reference model predicts every output on every cycle. A small
// in-order memory model with variable latency and the PC logic form the
// environment. Directed phases pin the model with literal expectations, and a
// randomized phase follows. Build with FETCH_QUEUE_BYPASS_EN to check the forward mode.
`timescale 1ns/1ps
module tb_fetch_queue;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'hE1A00000;
    localparam logic [31:0] XORK  = 32'hA5A5_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int          BYPASS = 1;
`else
    localparam int          BYPASS = 0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        redirect;
    logic        pc_update;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;

    fetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .redirect        (redirect),
        .pc_update       (pc_update),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_inst         (id_inst),
        .id_pc           (id_pc),
        .id_ready        (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- Reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        filled;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    int          drop;
    logic        mon_en = 1'b0;
    bit          m_head_f, m_keep, m_byp, m_rv, m_fire, m_iv;
    logic [31:0] m_inst;
    int          m_unf;
    ent_t        m_tmp;

    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
            drop = 0;
        end else if (mon_en) begin
            m_head_f = (mq.size() > 0) && mq[0].filled;
            m_keep   = imem_resp_valid && (drop == 0);
            m_byp    = (BYPASS != 0) && (mq.size() > 0) && !m_head_f && m_keep;
            m_rv     = !redirect && (mq.size() < DEPTH);
            m_fire   = m_rv && imem_req_ready;
            m_iv     = !redirect && (m_head_f || m_byp);
            m_inst   = NOP;
            if (m_iv) m_inst = m_head_f ? mq[0].inst : imem_resp_data;

            check("req_valid", 32'(imem_req_valid), 32'(m_rv));
            if (m_rv) check("req_addr", imem_req_addr, pc);
            check("pc_update", 32'(pc_update), 32'(m_fire || redirect));
            check("id_valid", 32'(id_valid), 32'(m_iv));
            check("id_inst", id_inst, m_inst);
            if (m_iv) check("id_pc", id_pc, mq[0].pc);

            if (redirect) begin
                m_unf = 0;
                foreach (mq[i]) if (!mq[i].filled) m_unf++;
                drop = drop + m_unf - (imem_resp_valid ? 1 : 0);
                mq.delete();
            end else begin
                if (imem_resp_valid) begin
                    if (drop > 0) drop--;
                    else begin
                        for (int i = 0; i < mq.size(); i++) begin
                            if (!mq[i].filled) begin
                                m_tmp        = mq[i];
                                m_tmp.filled = 1'b1;
                                m_tmp.inst   = imem_resp_data;
                                mq[i]        = m_tmp;
                                break;
                            end
                        end
                    end
                end
                if (m_iv && id_ready) void'(mq.pop_front());
                if (m_fire) begin
                    m_tmp.pc     = pc;
                    m_tmp.filled = 1'b0;
                    m_tmp.inst   = 32'h0;
                    mq.push_back(m_tmp);
                end
            end
        end
    end

    // ---------------- Environment: memory and PC logic ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        memq[$];
    req_t        r_tmp;
    logic [31:0] pc_reg;
    int          cyc;
    int          lat;
    int          last_due;
    int          first_valid_cyc;
    logic        s_fire, s_upd, s_rv;
    logic [31:0] s_addr;
    logic [31:0] acc_pc[$];

    // One clock cycle: drive inputs, sample at the falling edge, then advance the environment
    task automatic cycle(input logic rdy, input logic idr, input logic redir, input logic [31:0] tgt);
        imem_req_ready = rdy;
        id_ready       = idr;
        pc             = pc_reg;
        redirect       = redir && (memq.size() <= DEPTH);
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memq[0].addr ^ XORK;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        @(negedge clk);
        s_rv   = imem_req_valid;
        s_fire = imem_req_valid && imem_req_ready;
        s_addr = imem_req_addr;
        s_upd  = pc_update;
        if (id_valid && id_ready) acc_pc.push_back(id_pc);
        if (id_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        @(posedge clk);
        #1;
        if (imem_resp_valid) void'(memq.pop_front());
        if (s_fire) begin
            r_tmp.addr = s_addr;
            r_tmp.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due   = r_tmp.due;
            memq.push_back(r_tmp);
        end
        if (redirect) pc_reg = tgt;
        else if (s_upd) pc_reg = pc_reg + 32'd4;
        cyc++;
    endtask

    function automatic logic [31:0] acc_at(input int k);
        return (acc_pc.size() > k) ? acc_pc[k] : 32'hDEAD_BEEF;
    endfunction

    logic [31:0] last_a, base;
    logic        u0, u1, u2, u3;

    initial begin
        // NOTE: inputs are driven with blocking assignments from this process, away from the sampling edge.
        reset = 1'b1; pc = '0; redirect = 1'b0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = '0; id_ready = 1'b0;
        pc_reg = '0; cyc = 0; lat = 1; last_due = -1; first_valid_cyc = -1;
        repeat (2) @(posedge clk);
        // Outputs must stay quiet under reset even with ready and redirect asserted
        imem_req_ready = 1'b1;
        redirect       = 1'b1;
        @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_pc_update", 32'(pc_update), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_inst", id_inst, NOP);
        check("rst_id_pc", id_pc, 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        redirect = 1'b0;
        mon_en   = 1'b1;

        // Phase A: 1-cycle memory, decode always ready, PC steps by 4 from 0
        repeat (20) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("first_valid_cycle", 32'(first_valid_cyc), (BYPASS != 0) ? 32'd1 : 32'd2);
        for (int k = 0; k < 6; k++) check("seqA_pc", acc_at(k), 32'(4 * k));
        last_a = acc_pc[$];

        // Phase B: decode stalled for 6 cycles, then released
        acc_pc.delete();
        repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("stall_req_valid", 32'(s_rv), 32'd0);
        check("stall_pc_update", 32'(s_upd), 32'd0);
        check("stall_no_accept", 32'(acc_pc.size()), 32'd0);
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("release_pc0", acc_at(0), last_a + 32'd4);
        check("release_pc1", acc_at(1), last_a + 32'd8);

        // Phase C: redirect to 0x100 with two reads outstanding (latency 3)
        lat = 3;
        repeat (8) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h100);
        acc_pc.delete();
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("redir_pc0", acc_at(0), 32'h100);
        check("redir_pc1", acc_at(1), 32'h104);

        // Phase D: redirect to 0x200 in the same cycle as a response
        repeat (8) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        acc_pc.delete();
        cycle(1'b0, 1'b1, 1'b1, 32'h200);
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("redir_resp_pc0", acc_at(0), 32'h200);
        check("redir_resp_pc1", acc_at(1), 32'h204);

        // Phase E: memory ready toggling 1,0,0,1
        lat = 1;
        repeat (6) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        acc_pc.delete();
        base = pc_reg;
        cycle(1'b1, 1'b1, 1'b0, 32'h0); u0 = s_upd;
        cycle(1'b0, 1'b1, 1'b0, 32'h0); u1 = s_upd;
        cycle(1'b0, 1'b1, 1'b0, 32'h0); u2 = s_upd;
        cycle(1'b1, 1'b1, 1'b0, 32'h0); u3 = s_upd;
        repeat (6) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("toggle_upd0", 32'(u0), 32'd1);
        check("toggle_upd1", 32'(u1), 32'd0);
        check("toggle_upd2", 32'(u2), 32'd0);
        check("toggle_upd3", 32'(u3), 32'd1);
        check("toggle_pc0", acc_at(0), base);
        check("toggle_pc1", acc_at(1), base + 32'd4);

        // Phase F: randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 4);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, 32'($urandom_range(0, 1023)) << 2);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
